mmio_result_responder: RTL and testbench
========================================

Name: mmio_result_responder

Overview:
- Memory-mapped responder on the multicycle MIPS data bus, between the topmulti memory port and the unified RAM.
- Decodes an I/O window plus one legacy result address, and steers stores and reads between the RAM and its own registers.
- Provides a cycle counter, a down-timer and a watchdog.
- Latches a synthesizable pass/fail verdict from the program's result store, so self-check runs on FPGA without a simulator.

Parameters:
- IO_BASE, 32'hFFFF_FF00, base of the 16-byte I/O window; adr[31:4] match selects I/O.
- RESULT_ADR, 32'd108, legacy result word address; a store here goes to RAM and is also checked.
- EXPECT, 32'd65035, value that counts as a pass.
- TIMEOUT, 32'd100000, watchdog limit in cycles.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- memwrite  in  1  CPU store strobe
- adr  in  32  CPU byte address; adr[1:0] ignored
- writedata  in  32  CPU store data
- ramreaddata  in  32  read data from RAM
- readdata  out  32  read data to CPU, combinational
- ramwe  out  1  RAM write enable = memwrite & ~io_sel
- done  out  1  verdict valid
- pass  out  1  verdict is pass; meaningful only when done=1
- cycles  out  32  current CYCLE register

Behaviour:
- io_sel = (adr[31:4] == IO_BASE[31:4]). readdata = io_sel ? selected register : ramreaddata. Combinational, so the existing MEMREAD-to-latch timing of the CPU FSM is unchanged.
- Register map (offset = adr[3:2]):
  - 0 CYCLE, RO: cycles since reset.
  - 1 TIMER, RW: down-counter.
  - 2 STATUS: read returns {28'b0, timeout, expired, pass, done}. Write is W1C on bit2 only.
  - 3 RESULT: write-only, reads 0.
- Writes to RO bits are ignored.
- FSM states RUN, DONE_PASS, DONE_FAIL. Reset -> RUN.
  - Verdict trigger: memwrite & (io_sel & offset 3 | adr == RESULT_ADR).
  - RUN, trigger: DONE_PASS if writedata == EXPECT, else DONE_FAIL.
  - RUN, CYCLE == TIMEOUT-1 without a trigger: DONE_FAIL with timeout=1.
  - Trigger and timeout in the same cycle: the trigger wins, timeout stays 0.
  - DONE_*: terminal until reset. Later result stores are ignored by the FSM; a store to RESULT_ADR still reaches RAM.
- Outputs: done=1 in either DONE state; pass=1 only in DONE_PASS. Verdict visible the cycle after the triggering edge (1-cycle latency).
- CYCLE: 0 at reset. Increments in RUN, frozen in DONE. Saturates at 32'hFFFF_FFFF.
- TIMER:
  - A write loads writedata.
  - If nonzero and not being written, decrements by 1 each cycle.
  - The 1->0 transition sets expired (sticky).
  - Load and decrement in the same cycle: the load wins.
  - Loading 0 does not set expired.
  - W1C clear and set in the same cycle: the set wins.
- Reset values, applied on any reset including mid-run:
  - CYCLE=0, TIMER=0, expired=0, timeout=0, state=RUN.
  - done=0, pass=0, cycles=0.
  - readdata reflects ramreaddata or registers combinationally; ramwe follows memwrite.

Decomposition:
- Shared package mmio_pkg holds:
  - IO_BASE default;
  - register offset constants (CYCLE_OFS=2'd0, TIMER_OFS=2'd1, STATUS_OFS=2'd2, RESULT_OFS=2'd3);
  - STATUS bit positions;
  - the FSM state encoding.
- One natural sub-module: mmio_down_timer (load, decrement, sticky expired, W1C).

Test Plan:
- Reset asserted for 2 cycles, then released; idle bus -> done=0, pass=0; cycles=5 after 5 edges; read at IO_BASE returns 5.
- sw 65035 to 108 -> ramwe=1; done=1, pass=1 next cycle; cycles frozen. A later sw 0 to 108 leaves pass=1.
- sw 7 to IO_BASE+12 -> ramwe=0; done=1, pass=0; STATUS read = 32'h1.
- Write TIMER=3 -> expired set 3 cycles later; STATUS bit2=1. W1C write 32'h4 to STATUS -> bit2=0.
- TIMEOUT=20 with no result store -> at cycle 20, done=1, pass=0, STATUS=32'h9. Trigger landing at CYCLE=19 instead -> timeout=0.
- Reset asserted while in DONE_PASS -> next cycle done=0, cycles=0, TIMER=0; normal run resumes.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO result responder: I/O window, register map,
// STATUS bit layout and verdict FSM encoding.
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [1:0] CYCLE_OFS  = 2'd0;
    localparam logic [1:0] TIMER_OFS  = 2'd1;
    localparam logic [1:0] STATUS_OFS = 2'd2;
    localparam logic [1:0] RESULT_OFS = 2'd3;

    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_PASS_BIT    = 1;
    localparam int STATUS_EXPIRED_BIT = 2;
    localparam int STATUS_TIMEOUT_BIT = 3;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DONE_PASS = 2'd1,
        ST_DONE_FAIL = 2'd2
    } state_t;

    function automatic logic [31:0] status_word(input logic done, input logic pass,
                                                input logic expired, input logic timeout);
        logic [31:0] w;
        w = '0;
        w[STATUS_DONE_BIT]    = done;
        w[STATUS_PASS_BIT]    = pass;
        w[STATUS_EXPIRED_BIT] = expired;
        w[STATUS_TIMEOUT_BIT] = timeout;
        return w;
    endfunction

endpackage

// File: rtl/mmio_down_timer.sv
// Software-loaded down-counter with a sticky expired flag that is cleared by
// a write-one-to-clear; a simultaneous 1->0 transition beats the clear.
module mmio_down_timer
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        clear_expired,
    output logic [31:0] count,
    output logic        expired
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            if (load) begin
                count <= load_value;
            end else if (count != '0) begin
                count <= count - 32'd1;
            end

            // A load in the same cycle pre-empts the 1->0 step, so no set then.
            if (!load && count == 32'd1) begin
                expired <= 1'b1;
            end else if (clear_expired) begin
                expired <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_result_responder.sv
// Data-bus responder: decodes the I/O window, steers RAM writes, runs the
// cycle counter, down-timer and watchdog, and latches the pass/fail verdict.
module mmio_result_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter logic [31:0] RESULT_ADR = 32'd108,
    parameter logic [31:0] EXPECT     = 32'd65035,
    parameter logic [31:0] TIMEOUT    = 32'd100000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic [31:0] ramreaddata,
    output logic [31:0] readdata,
    output logic        ramwe,
    output logic        done,
    output logic        pass,
    output logic [31:0] cycles
);

    state_t      state_q, state_d;
    logic        timeout_q, timeout_set;
    logic [31:0] cycle_q;
    logic [31:0] timer_count;
    logic        timer_expired;

    logic       io_sel;
    logic [1:0] offset;
    logic       trigger;
    logic       timeout_hit;

    assign io_sel      = (adr[31:4] == IO_BASE[31:4]);
    assign offset      = adr[3:2];
    assign trigger     = memwrite & ((io_sel & (offset == RESULT_OFS)) | (adr == RESULT_ADR));
    assign timeout_hit = (cycle_q == TIMEOUT - 32'd1);

    assign ramwe  = memwrite & ~io_sel;
    assign done   = (state_q != ST_RUN);
    assign pass   = (state_q == ST_DONE_PASS);
    assign cycles = cycle_q;

    mmio_down_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .load         (memwrite & io_sel & (offset == TIMER_OFS)),
        .load_value   (writedata),
        .clear_expired(memwrite & io_sel & (offset == STATUS_OFS) & writedata[STATUS_EXPIRED_BIT]),
        .count        (timer_count),
        .expired      (timer_expired)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A result store on the watchdog's last cycle still wins.
                if (trigger) begin
                    state_d = (writedata == EXPECT) ? ST_DONE_PASS : ST_DONE_FAIL;
                end else if (timeout_hit) begin
                    state_d     = ST_DONE_FAIL;
                    timeout_set = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            timeout_q <= 1'b0;
            cycle_q   <= '0;
        end else begin
            state_q <= state_d;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (state_q == ST_RUN && cycle_q != '1) begin
                cycle_q <= cycle_q + 32'd1;
            end
        end
    end

    always_comb begin
        readdata = ramreaddata;
        if (io_sel) begin
            case (offset)
                CYCLE_OFS:  readdata = cycle_q;
                TIMER_OFS:  readdata = timer_count;
                STATUS_OFS: readdata = status_word(done, pass, timer_expired, timeout_q);
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_result_responder.sv
// Self-checking bench: decode table in a frozen DONE state, plus sequences
// for verdict latency, timer corners, watchdog race and mid-run reset.
module tb_mmio_result_responder;

    localparam logic [31:0] IO_BASE    = 32'hFFFF_FF00;
    localparam logic [31:0] RESULT_ADR = 32'd108;
    localparam logic [31:0] EXPECT     = 32'd65035;
    localparam logic [31:0] TIMEOUT    = 32'd20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] ramreaddata = '0;
    logic [31:0] readdata;
    logic        ramwe;
    logic        done;
    logic        pass;
    logic [31:0] cycles;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        memwrite;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] ramrd;
        logic        exp_ramwe;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic pass;
        logic timeout;
    } verdict_t;

    vec_t     vecs[13];
    verdict_t sb[$];

    mmio_result_responder #(
        .IO_BASE   (IO_BASE),
        .RESULT_ADR(RESULT_ADR),
        .EXPECT    (EXPECT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .adr        (adr),
        .writedata  (writedata),
        .ramreaddata(ramreaddata),
        .readdata   (readdata),
        .ramwe      (ramwe),
        .done       (done),
        .pass       (pass),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] ofs, output logic [31:0] d);
        memwrite = 1'b0;
        adr      = IO_BASE | {28'd0, ofs, 2'b00};
        #1;
        d = readdata;
    endtask

    // Called at a negedge; drives one store across the next rising edge.
    task automatic store(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_ramwe);
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        #1;
        check({name, " ramwe"}, ramwe, exp_ramwe);
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_verdict(input string name, input int budget);
        verdict_t    e;
        int          n;
        logic [31:0] st;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got none expected one entry", name);
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " done"}, done, 1);
        check({name, " pass"}, pass, e.pass);
        read_reg(2'd2, st);
        check({name, " timeout"}, st[3], e.timeout);
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{1'b0, 32'hFFFF_FF00, 32'h0,      32'hDEAD_BEEF, 1'b0, 32'd6};
        vecs[1]  = '{1'b0, 32'hFFFF_FF04, 32'h0,      32'h1111_1111, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 32'hFFFF_FF08, 32'h0,      32'h2222_2222, 1'b0, 32'h3};
        vecs[3]  = '{1'b0, 32'hFFFF_FF0C, 32'h0,      32'h3333_3333, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 32'hFFFF_FF0E, 32'h0,      32'h4444_4444, 1'b0, 32'd0};
        vecs[5]  = '{1'b0, 32'hFFFF_FEFC, 32'h0,      32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
        vecs[6]  = '{1'b0, 32'h0000_006C, 32'h0,      32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[7]  = '{1'b1, 32'h0000_0200, 32'h55,     32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, 32'hFFFF_FF00, 32'hFFFF,   32'h0,         1'b0, 32'd6};
        vecs[9]  = '{1'b0, 32'hFFFF_FF00, 32'h0,      32'h0,         1'b0, 32'd6};
        vecs[10] = '{1'b1, 32'hFFFF_FF08, 32'h3,      32'h0,         1'b0, 32'h3};
        vecs[11] = '{1'b0, 32'hFFFF_FF08, 32'h0,      32'h0,         1'b0, 32'h3};
        vecs[12] = '{1'b0, 32'hFFFF_FF10, 32'h0,      32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};

        // Reset, idle counting and CYCLE read.
        do_reset(2);
        check("reset cycles", cycles, 0);
        check("reset done", done, 0);
        check("reset pass", pass, 0);
        repeat (5) @(negedge clk);
        check("idle cycles", cycles, 5);
        check("idle done", done, 0);
        read_reg(2'd0, d);
        check("cycle read", d, 5);

        // Legacy result store with the expected value.
        sb.push_back('{1'b1, 1'b0});
        store("legacy pass", RESULT_ADR, EXPECT, 1'b1);
        wait_verdict("legacy pass", 0);
        check("cycles at verdict", cycles, 6);
        repeat (3) @(negedge clk);
        check("cycles frozen", cycles, 6);
        store("late store", RESULT_ADR, 32'd0, 1'b1);
        check("late store pass", pass, 1);
        check("late store done", done, 1);

        // Decode table applied while CYCLE is frozen.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            memwrite    = vecs[i].memwrite;
            adr         = vecs[i].adr;
            writedata   = vecs[i].wdata;
            ramreaddata = vecs[i].ramrd;
            #1;
            check($sformatf("vec%0d ramwe", i), ramwe, vecs[i].exp_ramwe);
            check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
        end
        @(negedge clk);
        memwrite = 1'b0;

        // Timer: load 3, expired appears on the third decrement.
        store("timer load3", IO_BASE + 32'd4, 32'd3, 1'b0);
        read_reg(2'd1, d);
        check("timer after load", d, 3);
        repeat (2) @(negedge clk);
        read_reg(2'd2, d);
        check("status before expiry", d, 32'h3);
        @(negedge clk);
        read_reg(2'd2, d);
        check("status expired", d, 32'h7);
        store("w1c", IO_BASE + 32'd8, 32'h4, 1'b0);
        read_reg(2'd2, d);
        check("status after w1c", d, 32'h3);

        // Clear and set on the same edge: the set wins.
        store("timer load1", IO_BASE + 32'd4, 32'd1, 1'b0);
        store("w1c race", IO_BASE + 32'd8, 32'h4, 1'b0);
        read_reg(2'd2, d);
        check("set beats clear", d, 32'h7);
        store("w1c again", IO_BASE + 32'd8, 32'h4, 1'b0);

        // Loading 0 over a pending 1->0 step: the load wins, no expiry.
        store("timer load1b", IO_BASE + 32'd4, 32'd1, 1'b0);
        store("timer load0", IO_BASE + 32'd4, 32'd0, 1'b0);
        read_reg(2'd2, d);
        check("load0 no expire", d, 32'h3);
        read_reg(2'd1, d);
        check("load0 timer", d, 0);

        // Reset while in DONE_PASS with a running timer.
        store("timer load9", IO_BASE + 32'd4, 32'd9, 1'b0);
        do_reset(1);
        check("midreset done", done, 0);
        check("midreset pass", pass, 0);
        check("midreset cycles", cycles, 0);
        read_reg(2'd1, d);
        check("midreset timer", d, 0);
        read_reg(2'd2, d);
        check("midreset status", d, 0);
        @(negedge clk);
        check("resume cycles", cycles, 1);

        // Wrong value written to the RESULT register.
        sb.push_back('{1'b0, 1'b0});
        store("io fail", IO_BASE + 32'd12, 32'd7, 1'b0);
        wait_verdict("io fail", 0);
        read_reg(2'd2, d);
        check("io fail status", d, 32'h1);

        // Watchdog expiry with no result store.
        do_reset(1);
        repeat (19) @(negedge clk);
        check("pre-timeout cycles", cycles, 19);
        check("pre-timeout done", done, 0);
        sb.push_back('{1'b0, 1'b1});
        wait_verdict("watchdog", 5);
        check("watchdog cycles", cycles, 20);
        read_reg(2'd2, d);
        check("watchdog status", d, 32'h9);

        // Result store on the watchdog's last cycle: trigger wins.
        do_reset(1);
        repeat (19) @(negedge clk);
        sb.push_back('{1'b1, 1'b0});
        store("race pass", IO_BASE + 32'd12, EXPECT, 1'b0);
        wait_verdict("race pass", 0);
        read_reg(2'd2, d);
        check("race status", d, 32'h3);
        check("race cycles", cycles, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
